// File: rtl/instr_fetch_unit.sv
// Edulent CPU fetch stage: owns PC, MA and IR, fetches opcode and operand
// bytes from program memory, and redirects PC on jumps.
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_next_instr,
  input  logic              i_operand_req,
  input  logic              i_pc_load,
  input  logic [ADDR_W-1:0] i_pc_val,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_opcode,
  output logic              o_opcode_valid,
  output logic [DATA_W-1:0] o_operand,
  output logic              o_operand_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    OPERAND = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ma_q, ma_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              req_q, req_d;
  logic              opcode_valid_q, opcode_valid_d;
  logic              operand_valid_q, operand_valid_d;
  logic [ADDR_W-1:0] target_pc;

  // Next-state and datapath decode; all outputs are taken from registers.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ma_d            = ma_q;
    ir_d            = ir_q;
    operand_d       = operand_q;
    req_d           = req_q;
    opcode_valid_d  = opcode_valid_q;
    operand_valid_d = 1'b0;
    // A jump taken together with next_instr/operand_req is applied before use.
    target_pc       = i_pc_load ? i_pc_val : pc_q;

    case (state_q)
      FETCH: begin
        if (!req_q) begin
          // First cycle out of reset: line MA up with PC and raise the request.
          ma_d  = pc_q;
          req_d = 1'b1;
        end else if (i_mem_ack) begin
          ir_d           = i_mem_rdata;
          pc_d           = pc_q + 1'b1;
          req_d          = 1'b0;
          opcode_valid_d = 1'b1;
          state_d        = HOLD;
        end
      end
      HOLD: begin
        if (i_next_instr) begin
          pc_d           = target_pc;
          ma_d           = target_pc;
          req_d          = 1'b1;
          opcode_valid_d = 1'b0;
          state_d        = FETCH;
        end else if (i_operand_req) begin
          pc_d    = target_pc;
          ma_d    = target_pc;
          req_d   = 1'b1;
          state_d = OPERAND;
        end else if (i_pc_load) begin
          pc_d = i_pc_val;
        end
      end
      OPERAND: begin
        if (i_mem_ack) begin
          operand_d       = i_mem_rdata;
          pc_d            = pc_q + 1'b1;
          req_d           = 1'b0;
          operand_valid_d = 1'b1;
          state_d         = HOLD;
        end
      end
      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= FETCH;
      pc_q            <= RESET_PC_V;
      ma_q            <= '0;
      ir_q            <= '0;
      operand_q       <= '0;
      req_q           <= 1'b0;
      opcode_valid_q  <= 1'b0;
      operand_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ma_q            <= ma_d;
      ir_q            <= ir_d;
      operand_q       <= operand_d;
      req_q           <= req_d;
      opcode_valid_q  <= opcode_valid_d;
      operand_valid_q <= operand_valid_d;
    end
  end

  assign o_mem_req       = req_q;
  assign o_busy          = req_q;
  assign o_mem_addr      = ma_q;
  assign o_opcode        = ir_q;
  assign o_opcode_valid  = opcode_valid_q;
  assign o_operand       = operand_q;
  assign o_operand_valid = operand_valid_q;
  assign o_pc            = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory responses are driven by hand
// from tasks, outputs are sampled on the falling edge or #1 after rising.
module tb_instr_fetch_unit;

  logic       clk;
  logic       rst;
  logic       next_instr;
  logic       operand_req;
  logic       pc_load;
  logic [7:0] pc_val;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] opcode;
  logic       opcode_valid;
  logic [7:0] operand;
  logic       operand_valid;
  logic [7:0] pc;
  logic       busy;

  int checks;
  int failures;

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(0)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_next_instr   (next_instr),
    .i_operand_req  (operand_req),
    .i_pc_load      (pc_load),
    .i_pc_val       (pc_val),
    .o_mem_req      (mem_req),
    .o_mem_addr     (mem_addr),
    .i_mem_ack      (mem_ack),
    .i_mem_rdata    (mem_rdata),
    .o_opcode       (opcode),
    .o_opcode_valid (opcode_valid),
    .o_operand      (operand),
    .o_operand_valid(operand_valid),
    .o_pc           (pc),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for a request, hold ack low for 'waits' cycles, then ack with 'data'.
  // Returns the cycles waited before req appeared, the number of cycles req
  // was seen high at a stable address, and the address of the request.
  task automatic serve(input int waits, input logic [7:0] data,
                       output int lat, output int cycles, output logic [7:0] addr);
    lat = 0;
    @(negedge clk);
    while (!mem_req && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL serve_timeout: mem_req=%b after %0d cycles, required 1", mem_req, lat);
    end
    addr   = mem_addr;
    cycles = 1;
    repeat (waits) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_addr === addr) cycles++;
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
  endtask

  // One-edge control pulse issued from a falling edge.
  task automatic pulse(input logic ni, input logic orq, input logic ld, input logic [7:0] val);
    @(negedge clk);
    next_instr  = ni;
    operand_req = orq;
    pc_load     = ld;
    pc_val      = val;
    @(posedge clk);
    #1;
    next_instr  = 1'b0;
    operand_req = 1'b0;
    pc_load     = 1'b0;
    pc_val      = 8'h00;
  endtask

  task automatic test_reset();
    int lat, cyc;
    logic [7:0] a;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, busy, opcode_valid, operand_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes: got %b required 0000", {mem_req, busy, opcode_valid, operand_valid});
    end
    checks++;
    if ({pc, mem_addr, opcode, operand} !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs: pc/ma/ir/op=%h required 00000000", {pc, mem_addr, opcode, operand});
    end
    rst = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_req: got %b required 0", mem_req);
    end
    // First fetch: request one cycle after release, 1-cycle ack.
    serve(0, 8'h19, lat, cyc, a);
    $display("reset fetch: addr=%h lat=%0d opcode=%h pc=%h", a, lat, opcode, pc);
    checks++;
    if (lat !== 0 || a !== 8'h00) begin
      failures++;
      $display("FAIL first_fetch_req: lat=%0d addr=%h required lat=0 addr=00", lat, a);
    end
    checks++;
    if (opcode !== 8'h19 || opcode_valid !== 1'b1 || pc !== 8'h01 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL first_fetch_out: opcode=%h v=%b pc=%h req=%b required 19 1 01 0",
               opcode, opcode_valid, pc, mem_req);
    end
  endtask

  task automatic test_operand();
    int lat, cyc;
    logic [7:0] a;
    pulse(1'b0, 1'b1, 1'b0, 8'h00);
    serve(3, 8'h5A, lat, cyc, a);
    $display("operand fetch: addr=%h req_cycles=%0d operand=%h pc=%h", a, cyc, operand, pc);
    checks++;
    if (cyc !== 4 || a !== 8'h01) begin
      failures++;
      $display("FAIL operand_req_hold: cycles=%0d addr=%h required 4 01", cyc, a);
    end
    checks++;
    if (operand !== 8'h5A || operand_valid !== 1'b1 || pc !== 8'h02 || opcode_valid !== 1'b1) begin
      failures++;
      $display("FAIL operand_out: op=%h ov=%b pc=%h v=%b required 5a 1 02 1",
               operand, operand_valid, pc, opcode_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (operand_valid !== 1'b0 || operand !== 8'h5A) begin
      failures++;
      $display("FAIL operand_pulse_end: ov=%b op=%h required 0 5a", operand_valid, operand);
    end
  endtask

  task automatic test_jump();
    int lat, cyc;
    logic [7:0] a;
    pulse(1'b1, 1'b0, 1'b1, 8'h40);
    checks++;
    if (opcode_valid !== 1'b0 || opcode !== 8'h19) begin
      failures++;
      $display("FAIL jump_valid_drop: v=%b opcode=%h required 0 19", opcode_valid, opcode);
    end
    serve(0, 8'h2C, lat, cyc, a);
    $display("jump fetch: addr=%h opcode=%h pc=%h", a, opcode, pc);
    checks++;
    if (a !== 8'h40 || opcode !== 8'h2C || pc !== 8'h41 || lat !== 0) begin
      failures++;
      $display("FAIL jump: addr=%h opcode=%h pc=%h lat=%0d required 40 2c 41 0", a, opcode, pc, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, cyc;
    logic [7:0] a;
    pulse(1'b0, 1'b0, 1'b1, 8'h50);
    checks++;
    if (pc !== 8'h50 || opcode_valid !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL hold_pc_load: pc=%h v=%b req=%b required 50 1 0", pc, opcode_valid, mem_req);
    end
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
    serve(2, 8'h3E, lat, cyc, a);
    $display("next fetch: addr=%h opcode=%h pc=%h", a, opcode, pc);
    checks++;
    if (a !== 8'h50 || opcode !== 8'h3E || pc !== 8'h51 || cyc !== 3) begin
      failures++;
      $display("FAIL next_no_jump: addr=%h opcode=%h pc=%h cyc=%0d required 50 3e 51 3", a, opcode, pc, cyc);
    end
  endtask

  task automatic test_wrap();
    int lat, cyc;
    logic [7:0] a;
    pulse(1'b1, 1'b0, 1'b1, 8'hFF);
    serve(0, 8'h11, lat, cyc, a);
    $display("wrap fetch: addr=%h opcode=%h pc=%h", a, opcode, pc);
    checks++;
    if (a !== 8'hFF || opcode !== 8'h11 || pc !== 8'h00) begin
      failures++;
      $display("FAIL wrap_fetch: addr=%h opcode=%h pc=%h required ff 11 00", a, opcode, pc);
    end
    pulse(1'b0, 1'b1, 1'b0, 8'h00);
    serve(1, 8'h77, lat, cyc, a);
    $display("wrap operand: addr=%h operand=%h pc=%h", a, operand, pc);
    checks++;
    if (a !== 8'h00 || operand !== 8'h77 || pc !== 8'h01) begin
      failures++;
      $display("FAIL wrap_operand: addr=%h op=%h pc=%h required 00 77 01", a, operand, pc);
    end
  endtask

  task automatic test_reset_in_operand();
    int lat, cyc, t;
    logic [7:0] a;
    pulse(1'b0, 1'b1, 1'b0, 8'h00);
    t = 0;
    while (!mem_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin
      failures++;
      $display("FAIL rst_op_req: req=%b addr=%h required 1 01", mem_req, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || operand !== 8'h00 || pc !== 8'h00) begin
      failures++;
      $display("FAIL rst_async: req=%b busy=%b op=%h pc=%h required 0 0 00 00", mem_req, busy, operand, pc);
    end
    mem_ack   = 1'b1;
    mem_rdata = 8'hAA;
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    checks++;
    if (operand !== 8'h00 || operand_valid !== 1'b0 || opcode !== 8'h00) begin
      failures++;
      $display("FAIL rst_ack_ignored: op=%h ov=%b opcode=%h required 00 0 00", operand, operand_valid, opcode);
    end
    @(negedge clk);
    rst = 1'b0;
    serve(0, 8'h19, lat, cyc, a);
    $display("restart fetch: addr=%h opcode=%h pc=%h", a, opcode, pc);
    checks++;
    if (a !== 8'h00 || opcode !== 8'h19 || pc !== 8'h01 || operand !== 8'h00) begin
      failures++;
      $display("FAIL restart: addr=%h opcode=%h pc=%h op=%h required 00 19 01 00", a, opcode, pc, operand);
    end
  endtask

  task automatic test_ignored();
    int lat, cyc;
    logic [7:0] a;
    // Spurious ack while nothing is requested.
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 8'hEE;
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    checks++;
    if (pc !== 8'h01 || opcode !== 8'h19 || operand_valid !== 1'b0 || operand !== 8'h00) begin
      failures++;
      $display("FAIL spurious_ack: pc=%h opcode=%h ov=%b op=%h required 01 19 0 00", pc, opcode, operand_valid, operand);
    end
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
    // Controls during FETCH with no ack must not disturb anything.
    pulse(1'b1, 1'b1, 1'b1, 8'h33);
    checks++;
    if (pc !== 8'h01 || mem_addr !== 8'h01 || mem_req !== 1'b1 || opcode_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ignore: pc=%h addr=%h req=%b v=%b required 01 01 1 0", pc, mem_addr, mem_req, opcode_valid);
    end
    serve(1, 8'h5A, lat, cyc, a);
    $display("ignored-ctl fetch: addr=%h opcode=%h pc=%h", a, opcode, pc);
    checks++;
    if (a !== 8'h01 || opcode !== 8'h5A || pc !== 8'h02 || operand !== 8'h00 || opcode_valid !== 1'b1) begin
      failures++;
      $display("FAIL fetch_after_ignore: addr=%h opcode=%h pc=%h op=%h v=%b required 01 5a 02 00 1",
               a, opcode, pc, operand, opcode_valid);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    next_instr  = 1'b0;
    operand_req = 1'b0;
    pc_load     = 1'b0;
    pc_val      = 8'h00;
    mem_ack     = 1'b0;
    mem_rdata   = 8'h00;
    test_reset();
    test_operand();
    test_jump();
    test_back_to_back();
    test_wrap();
    test_reset_in_operand();
    test_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
